uart_ctrl_fifo: RTL and testbench

//  Wishbone-mapped UART controller with parametrised RX/TX FIFOs, a TX launch FSM, sticky error flags and a maskable interrupt.

---
 rtl/uart_ctrl_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_ctrl_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl_fifo.sv
// Wishbone-mapped UART controller: RX/TX FIFOs, TX launch FSM, sticky
// error flags, maskable level interrupt. Single clock, synchronous reset.
module uart_ctrl_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_valid,
    input  logic [31:0]       i_wb_adr,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    output logic              o_wb_ack,
    output logic [31:0]       o_wb_dat,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_frame_err,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_busy,
    output logic              o_irq
);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned RCW = RAW + 1;
    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned TCW = TAW + 1;

    localparam logic [31:0] A_RX   = BASE_ADR;
    localparam logic [31:0] A_TX   = BASE_ADR + 32'h4;
    localparam logic [31:0] A_STAT = BASE_ADR + 32'h8;
    localparam logic [31:0] A_CTRL = BASE_ADR + 32'hC;
    localparam logic [31:0] A_LVL  = BASE_ADR + 32'h10;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;

    tx_state_t         tx_state, tx_next;
    logic              tx_launch;

    logic              acc, rd_acc, wr_acc;
    logic              hit_rx, hit_tx, hit_stat, hit_ctrl, hit_lvl;

    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]    rx_wp, rx_rp;
    logic [RCW-1:0]    rx_cnt;
    logic              rx_empty, rx_full, rx_req, rx_push, rx_pop, rx_flush;

    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TAW-1:0]    tx_wp, tx_rp;
    logic [TCW-1:0]    tx_cnt;
    logic              tx_empty, tx_full, tx_req, tx_push, tx_pop, tx_flush;

    logic              rx_ovr, fe, tx_ovr, stat_rd;
    logic [2:0]        ctrl_en;
    logic [7:0]        stat;
    logic [31:0]       rd_data;
    logic              unused_inputs;

    assign unused_inputs = ^{i_wb_sel, i_wb_dat};

    assign acc      = i_wb_valid && !o_wb_ack;
    assign rd_acc   = acc && !i_wb_we;
    assign wr_acc   = acc && i_wb_we;
    assign hit_rx   = (i_wb_adr == A_RX);
    assign hit_tx   = (i_wb_adr == A_TX);
    assign hit_stat = (i_wb_adr == A_STAT);
    assign hit_ctrl = (i_wb_adr == A_CTRL);
    assign hit_lvl  = (i_wb_adr == A_LVL);

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == RCW'(RX_DEPTH));
    assign rx_req   = i_rx_valid && !i_frame_err;
    assign rx_pop   = rd_acc && hit_rx && !rx_empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign rx_push  = rx_req && (!rx_full || rx_pop);
    assign rx_flush = wr_acc && hit_ctrl && i_wb_dat[8];

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == TCW'(TX_DEPTH));
    assign tx_req   = wr_acc && hit_tx;
    assign tx_pop   = tx_launch;
    assign tx_push  = tx_req && (!tx_full || tx_pop);
    assign tx_flush = wr_acc && hit_ctrl && i_wb_dat[9];

    assign stat_rd  = rd_acc && hit_stat;
    assign stat     = {tx_state != IDLE, tx_ovr, fe, rx_ovr, tx_full, tx_empty, rx_full, rx_empty};

    // RX storage write port
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= i_rx_data;
    end

    // RX pointers and occupancy; flush drops everything at once
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
            rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
        end
    end

    // TX storage write port
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= i_wb_dat[DATA_W-1:0];
    end

    // TX pointers and occupancy; a character popped by a launch still goes out on flush
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TAW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
            tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
        end
    end

    // TX launch FSM next state
    always_comb begin
        tx_next   = tx_state;
        tx_launch = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!tx_empty && !i_tx_busy) begin
                    tx_launch = 1'b1;
                    tx_next   = LAUNCH;
                end
            end
            LAUNCH:    tx_next = WAIT_BUSY;
            WAIT_BUSY: if (i_tx_busy)  tx_next = WAIT_DONE;
            WAIT_DONE: if (!i_tx_busy) tx_next = IDLE;
            default:   tx_next = IDLE;
        endcase
    end

    // TX FSM state, launch pulse and held character
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= IDLE;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            tx_state   <= tx_next;
            o_tx_start <= tx_launch;
            if (tx_launch) o_tx_data <= tx_mem[tx_rp];
        end
    end

    // Sticky flags (set beats a same-cycle read clear) and control enables
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovr  <= 1'b0;
            fe      <= 1'b0;
            tx_ovr  <= 1'b0;
            ctrl_en <= '0;
        end else begin
            rx_ovr <= (rx_req && rx_full && !rx_pop) || (rx_ovr && !stat_rd);
            fe     <= (i_rx_valid && i_frame_err)    || (fe && !stat_rd);
            tx_ovr <= (tx_req && tx_full && !tx_pop) || (tx_ovr && !stat_rd);
            if (wr_acc && hit_ctrl) ctrl_en <= i_wb_dat[2:0];
        end
    end

    // Register read mux; unmapped and write-only addresses read 0
    always_comb begin
        rd_data = '0;
        if (hit_rx && !rx_empty) rd_data = {{(32-DATA_W){1'b0}}, rx_mem[rx_rp]};
        else if (hit_stat)       rd_data = {24'h0, stat};
        else if (hit_ctrl)       rd_data = {29'h0, ctrl_en};
        else if (hit_lvl)        rd_data = {{(16-TCW){1'b0}}, tx_cnt, {(16-RCW){1'b0}}, rx_cnt};
    end

    // Bus acknowledge, read data and interrupt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
            o_irq    <= 1'b0;
        end else begin
            o_wb_ack <= acc;
            if (acc) o_wb_dat <= i_wb_we ? '0 : rd_data;
            o_irq <= (ctrl_en[0] && !rx_empty) ||
                     (ctrl_en[1] && tx_empty && tx_state == IDLE) ||
                     (ctrl_en[2] && (rx_ovr || fe || tx_ovr));
        end
    end
endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// Self-checking bench for uart_ctrl_fifo: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_uart_ctrl_fifo;
    localparam int          DW   = 8;
    localparam int          RD   = 16;
    localparam int          TD   = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_RX = BASE, A_TX = BASE + 32'h4, A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC, A_LVL = BASE + 32'h10;

    logic          clk = 1'b0, rst = 1'b1;
    logic          i_wb_valid = 1'b0, i_wb_we = 1'b0;
    logic [31:0]   i_wb_adr = '0, i_wb_dat = '0;
    logic [3:0]    i_wb_sel = 4'hF;
    logic          o_wb_ack, o_tx_start, o_irq, i_tx_busy;
    logic [31:0]   o_wb_dat;
    logic [DW-1:0] i_rx_data = '0, o_tx_data;
    logic          i_rx_valid = 1'b0, i_frame_err = 1'b0;

    int n_tests = 0, n_fail = 0;

    uart_ctrl_fifo #(.DATA_W(DW), .RX_DEPTH(RD), .TX_DEPTH(TD), .BASE_ADR(BASE)) dut (
        .clk(clk), .rst(rst), .i_wb_valid(i_wb_valid), .i_wb_adr(i_wb_adr), .i_wb_we(i_wb_we),
        .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_frame_err(i_frame_err),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transmitter stand-in: after each launch, goes busy after a short random delay.
    logic busy_hold = 1'b0, tsim_busy = 1'b0, pending = 1'b0;
    int   dly = 0, len = 0;
    assign i_tx_busy = tsim_busy | busy_hold;
    always @(negedge clk) begin
        if (o_tx_start && !pending && !tsim_busy) begin
            pending = 1'b1;
            dly = int'($urandom_range(0, 2));
        end
        if (pending) begin
            if (dly == 0) begin
                pending = 1'b0; tsim_busy = 1'b1; len = int'($urandom_range(2, 5));
            end else dly--;
        end else if (tsim_busy) begin
            if (len == 0) tsim_busy = 1'b0; else len--;
        end
    end

    logic [7:0] launched[$];
    always @(negedge clk) if (o_tx_start) launched.push_back(o_tx_data);

    // Reference model: FIFOs as queues, flags as bits, transmitter handshake
    // tracked as "a character is out and its busy period has not ended yet".
    logic [7:0]  rxq[$], txq[$];
    bit          m_ack = 0, m_rd = 0, m_irq = 0, m_start = 0;
    logic [31:0] m_dat = '0;
    logic [7:0]  m_txd = '0;
    bit          f_rxo = 0, f_fe = 0, f_txo = 0;
    logic [2:0]  m_ctrl = '0;
    bit          t_act = 0, t_saw = 0;
    int          t_age = 0;

    task automatic model_step();
        bit acc, clr, launch, s_rxo, s_txo, s_fe, irq_n;
        logic [7:0]  st;
        logic [31:0] rdv;
        if (rst) begin
            rxq.delete(); txq.delete();
            m_ack = 0; m_rd = 0; m_irq = 0; m_start = 0; m_dat = '0; m_txd = '0;
            f_rxo = 0; f_fe = 0; f_txo = 0; m_ctrl = '0; t_act = 0; t_saw = 0; t_age = 0;
            return;
        end
        acc = i_wb_valid && !m_ack;
        st = {t_act, f_txo, f_fe, f_rxo, txq.size() == TD, txq.size() == 0,
              rxq.size() == RD, rxq.size() == 0};
        irq_n = (m_ctrl[0] && rxq.size() != 0) || (m_ctrl[1] && txq.size() == 0 && !t_act) ||
                (m_ctrl[2] && (f_rxo || f_fe || f_txo));
        rdv = '0;
        if (i_wb_adr == A_RX && rxq.size() != 0) rdv = 32'(rxq[0]);
        else if (i_wb_adr == A_STAT) rdv = 32'(st);
        else if (i_wb_adr == A_CTRL) rdv = 32'(m_ctrl);
        else if (i_wb_adr == A_LVL)  rdv = {16'(txq.size()), 16'(rxq.size())};
        // RX side
        s_rxo = 0; s_txo = 0;
        s_fe = i_rx_valid && i_frame_err;
        if (acc && !i_wb_we && i_wb_adr == A_RX && rxq.size() != 0) void'(rxq.pop_front());
        if (i_rx_valid && !i_frame_err) begin
            if (rxq.size() < RD) rxq.push_back(i_rx_data); else s_rxo = 1;
        end
        if (acc && i_wb_we && i_wb_adr == A_CTRL && i_wb_dat[8]) rxq.delete();
        // TX side
        launch = !t_act && txq.size() != 0 && !i_tx_busy;
        if (launch) m_txd = txq.pop_front();
        if (acc && i_wb_we && i_wb_adr == A_TX) begin
            if (txq.size() < TD) txq.push_back(i_wb_dat[7:0]); else s_txo = 1;
        end
        if (acc && i_wb_we && i_wb_adr == A_CTRL && i_wb_dat[9]) txq.delete();
        if (acc && i_wb_we && i_wb_adr == A_CTRL) m_ctrl = i_wb_dat[2:0];
        clr = acc && !i_wb_we && i_wb_adr == A_STAT;
        f_rxo = s_rxo || (f_rxo && !clr);
        f_fe  = s_fe  || (f_fe  && !clr);
        f_txo = s_txo || (f_txo && !clr);
        // Busy seen in the launch cycle itself is ignored; the character is done
        // once busy has been observed high and then low.
        if (launch) begin
            t_act = 1; t_saw = 0; t_age = 0;
        end else if (t_act) begin
            if (t_age >= 1 && !t_saw && i_tx_busy) t_saw = 1;
            else if (t_saw && !i_tx_busy) t_act = 0;
            t_age++;
        end
        m_start = launch;
        m_ack = acc;
        m_rd = acc && !i_wb_we;
        if (m_rd) m_dat = rdv;
        m_irq = irq_n;
    endtask

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        model_step();
        #1;
        check("ack", 32'(o_wb_ack), 32'(m_ack));
        if (m_ack && m_rd) check("rdata", o_wb_dat, m_dat);
        check("irq", 32'(o_irq), 32'(m_irq));
        check("tx_start", 32'(o_tx_start), 32'(m_start));
        check("tx_data", 32'(o_tx_data), 32'(m_txd));
    end

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        i_wb_valid = 1'b1; i_wb_we = 1'b0; i_wb_adr = a;
        @(negedge clk);
        check("rd_ack", 32'(o_wb_ack), 32'd1);
        d = o_wb_dat;
        i_wb_valid = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        i_wb_valid = 1'b1; i_wb_we = 1'b1; i_wb_adr = a; i_wb_dat = v;
        @(negedge clk);
        check("wr_ack", 32'(o_wb_ack), 32'd1);
        i_wb_valid = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wait_tx_drain(input int lim);
        int n = 0;
        while ((t_act || txq.size() != 0 || i_tx_busy || pending) && n < lim) begin
            @(negedge clk); n++;
        end
        check("drain_bound", 32'(n < lim), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_start", 32'(o_tx_start), 32'd0);
        wb_rd(A_STAT, d); check("rst_stat", d, 32'h05);
        wb_rd(A_LVL, d);  check("rst_level", d, 32'h0);

        // Three characters, launched one per busy period, in order
        launched.delete();
        wb_wr(A_TX, 32'h41); wb_wr(A_TX, 32'h42); wb_wr(A_TX, 32'h43);
        wait_tx_drain(300);
        check("tx_count", 32'(launched.size()), 32'd3);
        if (launched.size() == 3) begin
            check("tx_c0", 32'(launched[0]), 32'h41);
            check("tx_c1", 32'(launched[1]), 32'h42);
            check("tx_c2", 32'(launched[2]), 32'h43);
        end
        wb_rd(A_STAT, d); check("tx_done_stat", d, 32'h05);

        // 17 pushes into a 16-deep RX FIFO
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk); i_rx_valid = 1'b1; i_rx_data = 8'(i);
        end
        @(negedge clk); i_rx_valid = 1'b0;
        wb_rd(A_LVL, d);  check("rx_level16", d & 32'hFFFF, 32'd16);
        wb_rd(A_STAT, d); check("rx_ovr_set", (d >> 4) & 1, 32'd1);
        wb_rd(A_STAT, d); check("rx_ovr_clr", (d >> 4) & 1, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            wb_rd(A_RX, d); check("rx_order", d, 32'(i));
        end

        // Framing error: dropped, sticky flag, interrupt two cycles later
        wb_wr(A_CTRL, 32'h4);
        @(negedge clk); i_rx_valid = 1'b1; i_frame_err = 1'b1; i_rx_data = 8'h55;
        @(negedge clk); i_rx_valid = 1'b0; i_frame_err = 1'b0;
        check("fe_irq_early", 32'(o_irq), 32'd0);
        @(negedge clk);
        check("fe_irq", 32'(o_irq), 32'd1);
        wb_rd(A_LVL, d);  check("fe_nopush", d, 32'd0);
        wb_rd(A_STAT, d); check("fe_flag", (d >> 5) & 1, 32'd1);
        @(negedge clk);
        check("fe_irq_clr", 32'(o_irq), 32'd0);
        wb_wr(A_CTRL, 32'h0);

        // Simultaneous push and pop on a full RX FIFO
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); i_rx_valid = 1'b1; i_rx_data = 8'(100 + i);
        end
        @(negedge clk);
        i_rx_data = 8'hEE; i_wb_valid = 1'b1; i_wb_we = 1'b0; i_wb_adr = A_RX;
        @(negedge clk);
        i_rx_valid = 1'b0; i_wb_valid = 1'b0;
        check("pp_data", o_wb_dat, 32'd101);
        wb_rd(A_LVL, d);  check("pp_level", d & 32'hFFFF, 32'd16);
        wb_rd(A_STAT, d); check("pp_noovr", (d >> 4) & 1, 32'd0);
        wb_wr(A_CTRL, 32'h100);
        wb_rd(A_LVL, d);  check("rx_flush", d, 32'd0);

        // TX overflow with the transmitter held busy, then flush
        busy_hold = 1'b1;
        for (int i = 0; i < 17; i++) wb_wr(A_TX, 32'(8'h60 + i));
        wb_rd(A_STAT, d); check("tx_ovr", (d >> 6) & 1, 32'd1);
        check("tx_full", (d >> 3) & 1, 32'd1);
        wb_wr(A_CTRL, 32'h200);
        wb_rd(A_LVL, d);  check("tx_flush", d >> 16, 32'd0);
        busy_hold = 1'b0;

        // Random traffic; the per-cycle model comparison does the checking
        for (int c = 0; c < 3000; c++) begin
            int k;
            @(negedge clk);
            i_rx_valid  = ($urandom_range(0, 2) == 0);
            i_frame_err = i_rx_valid && ($urandom_range(0, 7) == 0);
            i_rx_data   = 8'($urandom);
            k = int'($urandom_range(0, 6));
            i_wb_valid = ($urandom_range(0, 2) != 0);
            i_wb_we    = 1'($urandom_range(0, 1));
            i_wb_adr   = (k == 6) ? 32'h0 : BASE + 32'(k * 4);
            if (k == 3) begin
                i_wb_dat = 32'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) i_wb_dat[8] = 1'b1;
                if ($urandom_range(0, 15) == 0) i_wb_dat[9] = 1'b1;
            end else i_wb_dat = $urandom;
        end
        @(negedge clk);
        i_wb_valid = 1'b0; i_wb_we = 1'b0; i_rx_valid = 1'b0; i_frame_err = 1'b0;
        repeat (2) @(negedge clk);
        wait_tx_drain(500);

        // Reset while the FSM waits for the transmitter to finish
        wb_wr(A_CTRL, 32'h7);
        wb_wr(A_TX, 32'h5A);
        n = 0;
        while (!o_tx_start && n < 20) begin @(negedge clk); n++; end
        check("rst_launch_bound", 32'(n < 20), 32'd1);
        busy_hold = 1'b1;
        wb_wr(A_TX, 32'h5B); wb_wr(A_TX, 32'h5C);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_irq", 32'(o_irq), 32'd0);
        check("mid_rst_start", 32'(o_tx_start), 32'd0);
        check("mid_rst_txd", 32'(o_tx_data), 32'd0);
        busy_hold = 1'b0;
        wb_rd(A_STAT, d); check("mid_rst_stat", d, 32'h05);
        wb_rd(A_LVL, d);  check("mid_rst_level", d, 32'd0);
        wb_rd(A_CTRL, d); check("mid_rst_ctrl", d, 32'd0);
        repeat (10) @(negedge clk);
        check("mid_rst_nolaunch", 32'(o_tx_start), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
